// File: rtl/trig_period_sequencer.sv
// Sequences a free-running counter: clears it, lets it run, counts ticks of one
// selected trigger bit, and pulses done (or aborted) when the sequence ends.
module trig_period_sequencer #(
    parameter int WIDTH  = 8,
    parameter int NPER_W = 8,
    parameter int SEL_W  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sel,
    input  logic [NPER_W-1:0] n_periods,
    input  logic [WIDTH-1:0]  trig_in,
    output logic              cnt_n_rst,
    output logic              cnt_n_en,
    output logic              ready,
    output logic              busy,
    output logic              period_tick,
    output logic [NPER_W-1:0] periods_left,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [NPER_W-1:0]  left_q, left_nxt;
    logic               aborted_q, aborted_nxt;
    logic [SEL_W-1:0]   sel_clamped;

    // Out-of-range selects fall back to the counter's MSB.
    assign sel_clamped = (int'(sel) > WIDTH - 1) ? SEL_W'(WIDTH - 1) : sel;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            left_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            left_q    <= left_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        left_nxt    = left_q;
        aborted_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sel_nxt   = sel_clamped;
                    left_nxt  = n_periods;
                    state_nxt = (n_periods == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    left_nxt    = '0;
                    aborted_nxt = 1'b1;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a coincident final tick.
                if (abort) begin
                    state_nxt   = S_IDLE;
                    left_nxt    = '0;
                    aborted_nxt = 1'b1;
                end else if (period_tick) begin
                    if (left_q <= NPER_W'(1)) begin
                        state_nxt = S_DONE;
                        left_nxt  = '0;
                    end else begin
                        left_nxt = left_q - NPER_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counter runs only in RUN, so stale trigger bits are flushed before each run.
    assign cnt_n_rst    = (state == S_RUN);
    assign cnt_n_en     = (state != S_RUN);
    assign ready        = (state == S_IDLE);
    assign busy         = (state == S_CLEAR) || (state == S_RUN);
    assign done         = (state == S_DONE);
    assign aborted      = aborted_q;
    assign period_tick  = (state == S_RUN) && trig_in[sel_q];
    assign periods_left = left_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_trig_period_sequencer.sv
// Directed bench for trig_period_sequencer driving a registered-trigger counter model.
module tb_trig_period_sequencer;
    localparam int WIDTH  = 8;
    localparam int NPER_W = 8;
    localparam int SEL_W  = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic              abort;
    logic [SEL_W-1:0]  sel;
    logic [NPER_W-1:0] n_periods;
    logic [WIDTH-1:0]  trig_in;
    logic              cnt_n_rst;
    logic              cnt_n_en;
    logic              ready;
    logic              busy;
    logic              period_tick;
    logic [NPER_W-1:0] periods_left;
    logic              done;
    logic              aborted;
    logic [1:0]        state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trig_period_sequencer #(.WIDTH(WIDTH), .NPER_W(NPER_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .sel(sel),
        .n_periods(n_periods), .trig_in(trig_in), .cnt_n_rst(cnt_n_rst),
        .cnt_n_en(cnt_n_en), .ready(ready), .busy(busy), .period_tick(period_tick),
        .periods_left(periods_left), .done(done), .aborted(aborted),
        .state_dbg(state_dbg)
    );

    // Counter model: trig bit i fires for one cycle after bits [i:0] were all ones.
    logic [WIDTH-1:0] cnt_q, trig_q, trig_nxt;
    always_comb begin
        trig_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            trig_nxt[i] = ((32'(cnt_q) & ((32'd1 << (i + 1)) - 1)) == ((32'd1 << (i + 1)) - 1));
        end
    end
    always_ff @(posedge clk) begin
        if (!cnt_n_rst) begin
            cnt_q  <= '0;
            trig_q <= '0;
        end else if (!cnt_n_en) begin
            cnt_q  <= cnt_q + 1'b1;
            trig_q <= trig_nxt;
        end
    end
    assign trig_in = trig_q;

    // {ready, busy, done, aborted, cnt_n_rst, cnt_n_en, period_tick}
    wire [6:0] flags = {ready, busy, done, aborted, cnt_n_rst, cnt_n_en, period_tick};
    localparam logic [6:0] F_IDLE = 7'b1000010;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start in the current cycle (cycle 0); returns in cycle 1.
    task automatic do_start(input logic [SEL_W-1:0] s, input logic [NPER_W-1:0] n);
        start = 1'b1;
        sel = s;
        n_periods = n;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; sel = '0; n_periods = '0;
        step(); step();
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (flags !== F_IDLE || periods_left !== 8'd0 || state_dbg !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d flags=%b pl=%0d st=%0d expected flags=%b pl=0 st=0",
                         c, flags, periods_left, state_dbg, F_IDLE);
            end
        end
    endtask

    task automatic test_basic();
        logic [6:0] ef;
        logic [7:0] ep;
        logic run;
        do_start(4'd0, 8'd3);
        for (int c = 1; c <= 10; c++) begin
            run = (c >= 2 && c <= 8);
            ef = {c == 10, c >= 1 && c <= 8, c == 9, 1'b0, run, !run, c == 4 || c == 6 || c == 8};
            ep = (c <= 4) ? 8'd3 : (c <= 6) ? 8'd2 : (c <= 8) ? 8'd1 : 8'd0;
            checks++;
            if (flags !== ef || periods_left !== ep) begin
                errors++;
                $display("FAIL basic c=%0d flags=%b pl=%0d expected flags=%b pl=%0d",
                         c, flags, periods_left, ef, ep);
            end
            step();
        end
    endtask

    task automatic test_sel2();
        logic [6:0] ef;
        logic [7:0] ep;
        logic run;
        do_start(4'd2, 8'd2);
        for (int c = 1; c <= 20; c++) begin
            run = (c >= 2 && c <= 18);
            ef = {c == 20, c >= 1 && c <= 18, c == 19, 1'b0, run, !run, c == 10 || c == 18};
            ep = (c <= 10) ? 8'd2 : (c <= 18) ? 8'd1 : 8'd0;
            checks++;
            if (flags !== ef || periods_left !== ep) begin
                errors++;
                $display("FAIL sel2 c=%0d flags=%b pl=%0d expected flags=%b pl=%0d",
                         c, flags, periods_left, ef, ep);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        int first_tick;
        first_tick = 0;
        do_start(4'd15, 8'd1);
        for (int c = 1; c <= 400; c++) begin
            if (period_tick) begin
                first_tick = c;
                break;
            end
            step();
        end
        checks++;
        if (first_tick !== 258) begin
            errors++;
            $display("FAIL clamp_first_tick cycle=%0d expected=258", first_tick);
        end
        step();
        checks++;
        if (done !== 1'b1 || periods_left !== 8'd0) begin
            errors++;
            $display("FAIL clamp_done done=%b pl=%0d expected done=1 pl=0", done, periods_left);
        end
        step();
    endtask

    task automatic test_zero_periods();
        do_start(4'd3, 8'd0);
        checks++;
        if (flags !== 7'b0010010 || periods_left !== 8'd0) begin
            errors++;
            $display("FAIL zero_done flags=%b pl=%0d expected flags=0010010 pl=0", flags, periods_left);
        end
        step();
        checks++;
        if (flags !== F_IDLE || cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL zero_after flags=%b cnt=%0d expected flags=%b cnt=0", flags, cnt_q, F_IDLE);
        end
    endtask

    task automatic test_abort_final();
        logic [6:0] ef;
        logic [7:0] ep;
        do_start(4'd1, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) ef = 7'b0100010;
            else if (c <= 6) ef = {6'b010010, c == 6};
            else if (c == 7) ef = 7'b1001010;
            else ef = F_IDLE;
            ep = (c <= 6) ? 8'd1 : 8'd0;
            checks++;
            if (flags !== ef || periods_left !== ep) begin
                errors++;
                $display("FAIL abort_final c=%0d flags=%b pl=%0d expected flags=%b pl=%0d",
                         c, flags, periods_left, ef, ep);
            end
            start = (c == 4);
            sel = 4'd0;
            n_periods = 8'd5;
            abort = (c == 6);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (cnt_q !== 8'd0 || cnt_n_rst !== 1'b0) begin
            errors++;
            $display("FAIL abort_counter_held cnt=%0d cnt_n_rst=%b expected cnt=0 cnt_n_rst=0",
                     cnt_q, cnt_n_rst);
        end
    endtask

    task automatic test_start_abort_idle();
        abort = 1'b1;
        do_start(4'd0, 8'd255);
        checks++;
        if (flags !== 7'b0100010 || periods_left !== 8'd255) begin
            errors++;
            $display("FAIL start_abort_idle flags=%b pl=%0d expected flags=0100010 pl=255",
                     flags, periods_left);
        end
        step();
        abort = 1'b0;
        checks++;
        if (flags !== 7'b1001010 || periods_left !== 8'd0) begin
            errors++;
            $display("FAIL abort_clear flags=%b pl=%0d expected flags=1001010 pl=0", flags, periods_left);
        end
        step();
        checks++;
        if (flags !== F_IDLE) begin
            errors++;
            $display("FAIL abort_pulse_width flags=%b expected flags=%b", flags, F_IDLE);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(4'd0, 8'd3);
        for (int c = 1; c < 5; c++) step();
        checks++;
        if (flags !== 7'b0100100 || periods_left !== 8'd2) begin
            errors++;
            $display("FAIL reset_mid_pre flags=%b pl=%0d expected flags=0100100 pl=2", flags, periods_left);
        end
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        checks++;
        if (flags !== F_IDLE || periods_left !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_idle flags=%b pl=%0d expected flags=%b pl=0",
                     flags, periods_left, F_IDLE);
        end
        step();
        checks++;
        if (flags !== F_IDLE) begin
            errors++;
            $display("FAIL reset_mid_no_pulse flags=%b expected flags=%b", flags, F_IDLE);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_sel2();
        test_clamp();
        test_zero_periods();
        test_abort_final();
        test_start_abort_idle();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
